axil4_monbus_stats: RTL
=======================

Name: axil4_monbus_stats

Overview:
- Sits directly downstream of an AXIL4 read/write monitor's 64-bit monitor bus output.
- Buffers packets in a small FIFO and forwards them unchanged to the system monitor-bus fabric.
- Classifies each accepted packet by type and maintains saturating error, transaction and drop counters. These are the status counts the monitor wrappers do not produce.
- Optionally drops packets instead of back-pressuring the monitor when the fabric stalls.

Parameters:
- FIFO_DEPTH, 4, packet buffer entries; power of two, 2..16.
- ERR_CNT_WIDTH, 16, width of error_count and dropped_count.
- TXN_CNT_WIDTH, 32, width of transaction_count.

Ports:
- aclk  input  1  clock
- areset  input  1  reset; asynchronous, active-high
- monbus_in_valid  input  1  packet valid from monitor
- monbus_in_ready  output  1  block can accept a packet
- monbus_in_packet  input  64  monitor packet
- monbus_out_valid  output  1  forwarded packet valid
- monbus_out_ready  input  1  downstream accepts
- monbus_out_packet  output  64  forwarded packet, bit-identical to input
- cfg_enable  input  1  enables counting; forwarding always active
- cfg_drop_on_full  input  1  1 = always ready and drop when full; 0 = back-pressure
- cfg_count_clear  input  1  single-cycle pulse that zeroes all counters
- error_count  output  ERR_CNT_WIDTH  ERROR + TIMEOUT packets seen
- transaction_count  output  TXN_CNT_WIDTH  COMPLETION packets seen
- dropped_count  output  ERR_CNT_WIDTH  packets discarded because FIFO was full
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
- busy  output  1  FIFO not empty

Behaviour:
- Reset (areset=1, asynchronous): FIFO empty; all counters 0; monbus_out_valid=0; busy=0; fifo_level=0. In back-pressure mode monbus_in_ready=0 while areset is high and becomes 1 on the first cycle after release.
- Packet type is packet[63:60]. Codes: 0 ERROR, 1 COMPLETION, 2 THRESHOLD, 3 TIMEOUT, 4 PERF, 5 ADDR_MATCH, 6 DEBUG. Codes 7-15 are forwarded but not counted.
- Accept event: monbus_in_valid & monbus_in_ready.
- Back-pressure mode: monbus_in_ready = !full. This is registered state only, with no combinational path from monbus_out_ready.
- Drop mode: monbus_in_ready = 1.
  - An accept while full with no pop in the same cycle discards the packet and increments dropped_count.
  - Full with a simultaneous pop: the packet is stored, not dropped.
- Latency: a packet pushed into an empty FIFO appears on monbus_out_valid on the next cycle; there is no bypass path. Throughput is one packet per cycle.
- monbus_out_packet and monbus_out_valid hold stable while valid & !ready. Packet order is strictly FIFO.
- Simultaneous push and pop: fifo_level is unchanged. Read and write pointers wrap modulo FIFO_DEPTH using an extra wrap bit.
- Counting happens on the accept event, including dropped packets, gated by cfg_enable. Counters update on the cycle after the accept.
- Counters saturate at all-ones and never wrap.
- cfg_count_clear takes priority: an increment in the same cycle is lost and the counter reads 0 next cycle.
- cfg_drop_on_full changing mid-traffic takes effect on the next cycle. FIFO contents are preserved.
- busy = (fifo_level != 0).

Decomposition:
- monitor_pkg holds:
  - the packet-type enum (PktTypeError..PktTypeDebug);
  - constants PKT_TYPE_MSB=63, PKT_TYPE_LSB=60;
  - a monbus_pkt_t 64-bit typedef.
- One sub-module, monbus_stats_fifo: a synchronous FIFO with parameterized depth, full/empty flags and level output.
- Classification and counters live in the top.

Test Plan:
- Reset then push 3 packets of type 1 with out_ready=1 -> each appears one cycle after push, in order; transaction_count=3; error_count=0.
- Push types 0, 3, 2, 4 -> error_count=2; transaction_count=0; all 4 forwarded unchanged.
- FIFO_DEPTH=4, back-pressure mode, out_ready=0, push 6 -> in_ready drops after the 4th; fifo_level=4; releasing out_ready drains 4 and then accepts the 2 held packets; dropped_count=0.
- Drop mode, out_ready=0, push 6 type-1 packets -> fifo_level=4; dropped_count=2; transaction_count=6. Drain yields the first 4 packets.
- Force error_count to 16'hFFFE via 65534 type-0 pushes, then push 3 more -> saturates at 16'hFFFF. A clear pulse in the same cycle as a type-0 push -> error_count=0 next cycle.
- Assert areset mid-burst with 3 packets queued -> outputs zero immediately and asynchronously; no stale packet is emitted after release.

Source files
------------

// File: rtl/monitor_pkg.sv
// monitor_pkg
// Shared definitions for the monitor-bus statistics block: the 64-bit
// monitor packet type, the location of the packet-type field and the
// packet-type codes produced by the AXIL4 read/write monitors.
package monitor_pkg;

    localparam int PKT_TYPE_MSB = 63;
    localparam int PKT_TYPE_LSB = 60;

    typedef logic [63:0] monbus_pkt_t;

    // Codes 7..15 are legal on the bus but carry no statistics meaning.
    typedef enum logic [3:0] {
        PktTypeError      = 4'd0,
        PktTypeCompletion = 4'd1,
        PktTypeThreshold  = 4'd2,
        PktTypeTimeout    = 4'd3,
        PktTypePerf       = 4'd4,
        PktTypeAddrMatch  = 4'd5,
        PktTypeDebug      = 4'd6
    } pkt_type_e;

    function automatic pkt_type_e pkt_type(input monbus_pkt_t pkt);
        return pkt_type_e'(pkt[PKT_TYPE_MSB:PKT_TYPE_LSB]);
    endfunction

endpackage

// File: rtl/monbus_stats_fifo.sv
// monbus_stats_fifo
// Synchronous packet FIFO with registered occupancy. Output data is read
// straight from the storage array at the read pointer, so a packet written
// into an empty FIFO becomes visible the cycle after the write (no bypass).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push, i_data  write request and packet
//   i_pop           read request (consumes o_data)
//   o_data          head-of-queue packet, valid while !o_empty
//   o_full/o_empty  occupancy flags
//   o_level         number of stored packets, 0..DEPTH
//
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module monbus_stats_fifo
    import monitor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  monbus_pkt_t              i_data,
    input  logic                     i_pop,
    output monbus_pkt_t              o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    monbus_pkt_t r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic [AW:0] w_level;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until the pointers say so.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/axil4_monbus_stats.sv
// axil4_monbus_stats
// Buffers the 64-bit monitor bus from an AXIL4 read/write monitor, forwards
// every packet unchanged and keeps saturating error / transaction / drop
// counters.
//
// Handshake: a transfer happens on a rising aclk edge where valid and ready
// are both high; valid must hold its packet stable until that edge, and ready
// is allowed to depend only on registered state.
//
// Ports:
//   aclk, areset                        clock, asynchronous active-high reset
//   monbus_in_valid/ready/packet        upstream monitor bus
//   monbus_out_valid/ready/packet       downstream monitor-bus fabric
//   cfg_enable                          counters advance only while high
//   cfg_drop_on_full                    1: always ready, drop when full
//   cfg_count_clear                     one-cycle pulse, zeroes counters
//   error_count                         ERROR + TIMEOUT packets accepted
//   transaction_count                   COMPLETION packets accepted
//   dropped_count                       packets discarded while full
//   fifo_level, busy                    occupancy, occupancy != 0
module axil4_monbus_stats
    import monitor_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_WIDTH = 16,
    parameter int TXN_CNT_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          monbus_in_valid,
    output logic                          monbus_in_ready,
    input  logic [63:0]                   monbus_in_packet,
    output logic                          monbus_out_valid,
    input  logic                          monbus_out_ready,
    output logic [63:0]                   monbus_out_packet,
    input  logic                          cfg_enable,
    input  logic                          cfg_drop_on_full,
    input  logic                          cfg_count_clear,
    output logic [ERR_CNT_WIDTH-1:0]      error_count,
    output logic [TXN_CNT_WIDTH-1:0]      transaction_count,
    output logic [ERR_CNT_WIDTH-1:0]      dropped_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    logic        r_ready_en;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_pop;
    logic        w_drop;
    logic        w_push;
    logic        w_count;
    pkt_type_e   w_type;
    logic        w_is_err;
    logic        w_is_txn;

    logic [ERR_CNT_WIDTH-1:0] r_error_count;
    logic [TXN_CNT_WIDTH-1:0] r_txn_count;
    logic [ERR_CNT_WIDTH-1:0] r_drop_count;

    // Keeps back-pressure ready low during reset and rises the cycle after
    // release, even though the empty FIFO would otherwise report !full.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_ready_en <= 1'b0;
        else        r_ready_en <= 1'b1;
    end

    assign monbus_in_ready  = cfg_drop_on_full ? 1'b1 : (r_ready_en & ~w_full);
    assign monbus_out_valid = ~w_empty;
    assign busy             = ~w_empty;

    assign w_accept = monbus_in_valid & monbus_in_ready;
    assign w_pop    = monbus_out_valid & monbus_out_ready;
    // Full with a concurrent pop still has room for the incoming packet.
    assign w_drop   = w_accept & w_full & ~w_pop;
    assign w_push   = w_accept & ~w_drop;

    assign w_type   = pkt_type(monbus_in_packet);
    assign w_is_err = (w_type == PktTypeError) || (w_type == PktTypeTimeout);
    assign w_is_txn = (w_type == PktTypeCompletion);
    assign w_count  = w_accept & cfg_enable;

    monbus_stats_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_push),
        .i_data  (monbus_in_packet),
        .i_pop   (w_pop),
        .o_data  (monbus_out_packet),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // Counters: clear wins over increment; increments stop at all-ones.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_error_count <= '0;
        end else if (cfg_count_clear) begin
            r_error_count <= '0;
        end else if (w_count && w_is_err && !(&r_error_count)) begin
            r_error_count <= r_error_count + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_txn_count <= '0;
        end else if (cfg_count_clear) begin
            r_txn_count <= '0;
        end else if (w_count && w_is_txn && !(&r_txn_count)) begin
            r_txn_count <= r_txn_count + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_drop_count <= '0;
        end else if (cfg_count_clear) begin
            r_drop_count <= '0;
        end else if (w_count && w_drop && !(&r_drop_count)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign error_count       = r_error_count;
    assign transaction_count = r_txn_count;
    assign dropped_count     = r_drop_count;

endmodule
